dff_share_ctrl: RTL
===================

Name: dff_share_ctrl

Overview:
- Round-robin controller that time-shares one external WIDTH-bit D-register between NUM_REQ requesters.
- Each transaction drives the register's d input, waits for q to settle, and returns the captured q to the winning requester.
- Also sequences a register clear on request, and flags any write whose read-back does not match the written data.
- Sits between requester agents and the shared flop's d/rst/q pins.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- WIDTH, 1, data width of the shared register.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester request; held until the matching ack.
- req_data  in  NUM_REQ*WIDTH  write data; slice i belongs to requester i.
- gnt  out  NUM_REQ  one-hot grant, high from grant until the end of the response.
- ack  out  NUM_REQ  one-hot, single-cycle completion pulse.
- rdata  out  WIDTH  captured q; valid while ack is high, held otherwise.
- clr_req  in  1  request to clear the shared register.
- clr_done  out  1  single-cycle clear-complete pulse.
- dff_d  out  WIDTH  drives the shared register d pin.
- dff_rst  out  1  drives the shared register rst pin.
- dff_q  in  WIDTH  shared register q.
- mismatch  out  1  sticky: a read-back differed from the written data.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Interface: one clock; reset is synchronous and active-high, ports named clk and rst.
- Reset (rst high at a posedge) returns every output to 0 and puts the FSM in IDLE.
  - Reset state: rr pointer = 0, mismatch cleared, dff_d = 0.
  - dff_rst = rst OR (state==CLEAR), so the shared flop resets together with the controller.
  - Reset mid-transaction aborts it; no ack and no clr_done are produced.
- FSM states: IDLE, DRIVE, CAPT, RESP, CLEAR, CCHK.
- IDLE:
  - clr_req high -> CLEAR. clr_req has priority over req.
  - Else, any req bit high -> pick the first set bit scanning from ptr upward with wrap.
  - On the pick: latch idx and dlat = req_data[idx]; register gnt[idx] = 1 and dff_d = dlat; go to DRIVE.
  - Else stay in IDLE.
- DRIVE: one cycle; the shared flop captures dff_d at the end of it. -> CAPT.
- CAPT: sample dff_q into rdata; if dff_q != dlat, set mismatch; assert ack[idx]. -> RESP.
- RESP: ack[idx] and gnt[idx] are high for exactly this cycle; ptr <= (idx+1) mod NUM_REQ. -> IDLE.
- Latency: req sampled at edge E0 -> ack high during cycle E2..E3 (3 cycles from request to completion).
- Requester handshake: the requester must drop req at the edge that ends RESP. A req still high in IDLE is treated as a new request.
- A req dropped before ack does not abort the transaction; ack is still issued.
- CLEAR: dff_rst high for one cycle. -> CCHK.
- CCHK: if dff_q != 0, set mismatch; pulse clr_done; -> IDLE. The pointer is unchanged.
- dff_d holds its last driven value outside DRIVE.
- No requester is starved: ptr always advances past the last winner.
- mismatch is cleared only by rst.

Test Plan:
- Reset: rst=1 for 2 cycles with req=4'b1111 -> gnt/ack/busy/mismatch/clr_done=0, dff_rst=1, dff_d=0; FSM in IDLE after release.
- Single write: req[2]=1, data[2]=1 at E0 -> gnt=4'b0100 from E1, dff_d=1, ack=4'b0100 and rdata=1 during the cycle starting E2, pointer=3.
- Round-robin: req=4'b1111 held and dropped per ack -> grant order 0,1,2,3,0; every grant 4 cycles apart (IDLE+DRIVE+CAPT+RESP).
- Clear priority: clr_req=1 and req=4'b0001 in the same IDLE cycle -> dff_rst pulses for 1 cycle, clr_done 2 cycles later, then requester 0 is granted.
- Mismatch: bench forces dff_q=0 while writing 1 -> rdata=0, mismatch=1 and staying 1 through later good transactions until rst.
- Reset mid-op: assert rst during DRIVE -> no ack, gnt=0 next cycle, pointer=0, the next req[1] is granted normally.

Source files
------------

// File: rtl/dff_share_ctrl.sv
// Round-robin controller that time-shares one external D-register between requesters,
// returning the read-back q to the winner and flagging read-back errors.
module dff_share_ctrl #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [NUM_REQ-1:0]       ack,
  output logic [WIDTH-1:0]         rdata,
  input  logic                     clr_req,
  output logic                     clr_done,
  output logic [WIDTH-1:0]         dff_d,
  output logic                     dff_rst,
  input  logic [WIDTH-1:0]         dff_q,
  output logic                     mismatch,
  output logic                     busy
);

  localparam int IDXW = $clog2(NUM_REQ);

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    CAPT,
    RESP,
    CLEAR,
    CCHK
  } state_t;

  state_t            state;
  logic [IDXW-1:0]   ptr;
  logic [IDXW-1:0]   idx;
  logic [WIDTH-1:0]  dlat;

  logic              pickValid;
  logic [IDXW-1:0]   pickIdx;
  logic [WIDTH-1:0]  pickData;
  int                cand;

  // Scan downward so the last hit written is the first set bit at or after ptr.
  always_comb begin
    pickValid = 1'b0;
    pickIdx   = '0;
    pickData  = '0;
    cand      = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = int'(ptr) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (req[cand]) begin
        pickValid = 1'b1;
        pickIdx   = IDXW'(cand);
        pickData  = req_data[cand*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      idx      <= '0;
      dlat     <= '0;
      gnt      <= '0;
      ack      <= '0;
      rdata    <= '0;
      clr_done <= 1'b0;
      dff_d    <= '0;
      mismatch <= 1'b0;
    end else begin
      ack      <= '0;
      clr_done <= 1'b0;
      case (state)
        IDLE: begin
          if (clr_req) begin
            state <= CLEAR;
          end else if (pickValid) begin
            idx   <= pickIdx;
            dlat  <= pickData;
            gnt   <= NUM_REQ'(1) << pickIdx;
            dff_d <= pickData;
            state <= DRIVE;
          end
        end
        DRIVE: state <= CAPT;
        CAPT: begin
          rdata <= dff_q;
          if (dff_q != dlat) mismatch <= 1'b1;
          ack   <= gnt;
          state <= RESP;
        end
        RESP: begin
          gnt   <= '0;
          ptr   <= (idx == IDXW'(NUM_REQ - 1)) ? '0 : idx + IDXW'(1);
          state <= IDLE;
        end
        CLEAR: state <= CCHK;
        CCHK: begin
          if (dff_q != '0) mismatch <= 1'b1;
          clr_done <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The shared flop is cleared together with the controller as well as on request.
  assign dff_rst = rst | (state == CLEAR);
  assign busy    = (state != IDLE);

endmodule
